// File: rtl/vga_dec_pkg.sv
// Shared constants and helpers for the VGA sync decoder: FSM encodings,
// counter widths and nominal 640x480 timing.
package vga_dec_pkg;

  localparam int CLK_CNT_W  = 12;
  localparam int LINE_CNT_W = 10;
  localparam int COORD_W    = 10;

  localparam int H_TOTAL_NOM      = 800;
  localparam int V_TOTAL_NOM      = 525;
  localparam int CLKS_PER_PIX_NOM = 2;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Saturating increment shared by x, y and the line counter (all 10 bit).
  function automatic logic [COORD_W-1:0] inc_sat(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Input register plus polarity-aware leading-edge detector for one sync line.
module vga_edge_det #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic level,
  output logic lead
);

  logic sig_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sig_reg  <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      sig_reg  <= sig;
      prev_reg <= sig_reg;
    end
  end

  assign level = sig_reg;
  assign lead  = (sig_reg == POL) && (prev_reg != POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel coordinates from hs/vs/video and monitors line/frame timing.
// Define VGA_DEC_STATS_EN to build the saturating error counter.
module vga_sync_decoder
  import vga_dec_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_NOM,
  parameter int V_TOTAL      = V_TOTAL_NOM,
  parameter int CLKS_PER_PIX = CLKS_PER_PIX_NOM,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hs,
  input  logic               vs,
  input  logic               video,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pix_valid,
  output logic               frame_start,
  output logic               locked,
  output logic               err_line,
  output logic               err_frame,
  output logic [15:0]        err_count
);

  localparam logic [CLK_CNT_W-1:0]  LINE_CLKS   = CLK_CNT_W'(H_TOTAL * CLKS_PER_PIX);
  localparam logic [CLK_CNT_W-1:0]  CLK_MAX     = '1;
  localparam logic [LINE_CNT_W-1:0] FRAME_LINES = LINE_CNT_W'(V_TOTAL);
  localparam logic [7:0]            SUB_LAST    = 8'(CLKS_PER_PIX - 1);

  logic hs_le, vs_le, vid_lvl, vid_re;
  logic hs_lvl_unused, vs_lvl_unused;

  vga_edge_det #(.POL(HS_POL != 0)) u_hs_det (
    .clk(clk), .reset(reset), .sig(hs), .level(hs_lvl_unused), .lead(hs_le));
  vga_edge_det #(.POL(VS_POL != 0)) u_vs_det (
    .clk(clk), .reset(reset), .sig(vs), .level(vs_lvl_unused), .lead(vs_le));
  vga_edge_det #(.POL(1'b1)) u_vid_det (
    .clk(clk), .reset(reset), .sig(video), .level(vid_lvl), .lead(vid_re));

  logic [1:0]            state_reg, state_next;
  logic                  hs_seen_reg, hs_seen_next;
  logic                  frame_err_reg, frame_err_next;
  logic [CLK_CNT_W-1:0]  clk_cnt_reg, clk_cnt_next;
  logic [LINE_CNT_W-1:0] line_cnt_reg, line_cnt_next, line_total;
  logic                  first_line_reg, first_line_next;
  logic [7:0]            sub_cnt_reg, sub_cnt_next;
  logic [COORD_W-1:0]    x_reg, x_next, y_reg, y_next;
  logic                  pix_valid_reg, pix_valid_next;
  logic                  frame_start_reg, locked_reg, err_line_reg, err_frame_reg;
  logic                  err_line_c, err_frame_c, clk_sat, go_search;

  // clk_cnt restarts at 1 so a nominal line reads exactly LINE_CLKS at the next edge.
  assign clk_sat    = (clk_cnt_reg == CLK_MAX);
  assign line_total = hs_le ? inc_sat(line_cnt_reg) : line_cnt_reg;
  assign err_line_c = hs_seen_reg &&
                      (hs_le ? (!clk_sat && (clk_cnt_reg != LINE_CLKS))
                             : (clk_cnt_reg == CLK_MAX - 1'b1));
  assign err_frame_c = vs_le && (state_reg != ST_SEARCH) && (line_total != FRAME_LINES);
  assign go_search   = (state_reg == ST_LOCKED) && (err_line_reg || err_frame_reg);

  always_comb begin
    state_next     = state_reg;
    frame_err_next = frame_err_reg;
    case (state_reg)
      ST_SEARCH:  if (vs_le) state_next = ST_ACQUIRE;
      ST_ACQUIRE: if (vs_le && !frame_err_reg && !err_line_c && !err_frame_c)
                    state_next = ST_LOCKED;
      ST_LOCKED:  if (go_search) state_next = ST_SEARCH;
      default:    state_next = ST_SEARCH;
    endcase
    if (vs_le)
      frame_err_next = 1'b0;
    else if (err_line_c)
      frame_err_next = 1'b1;

    hs_seen_next  = go_search ? 1'b0 : (hs_seen_reg || hs_le);
    clk_cnt_next  = hs_le ? CLK_CNT_W'(1) : (clk_sat ? clk_cnt_reg : clk_cnt_reg + 1'b1);
    line_cnt_next = vs_le ? '0 : line_total;
  end

  always_comb begin
    first_line_next = first_line_reg;
    sub_cnt_next    = sub_cnt_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    pix_valid_next  = 1'b0;
    if (vid_re) begin
      x_next         = '0;
      sub_cnt_next   = '0;
      pix_valid_next = 1'b1;
      if (first_line_reg) begin
        y_next          = '0;
        first_line_next = 1'b0;
      end else begin
        y_next = inc_sat(y_reg);
      end
    end else if (vid_lvl) begin
      if (sub_cnt_reg == SUB_LAST) begin
        sub_cnt_next   = '0;
        x_next         = inc_sat(x_reg);
        pix_valid_next = 1'b1;
      end else begin
        sub_cnt_next = sub_cnt_reg + 8'd1;
      end
    end
    if (vs_le)
      first_line_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_SEARCH;
      hs_seen_reg     <= 1'b0;
      frame_err_reg   <= 1'b0;
      clk_cnt_reg     <= '0;
      line_cnt_reg    <= '0;
      first_line_reg  <= 1'b0;
      sub_cnt_reg     <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      pix_valid_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
      locked_reg      <= 1'b0;
      err_line_reg    <= 1'b0;
      err_frame_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hs_seen_reg     <= hs_seen_next;
      frame_err_reg   <= frame_err_next;
      clk_cnt_reg     <= clk_cnt_next;
      line_cnt_reg    <= line_cnt_next;
      first_line_reg  <= first_line_next;
      sub_cnt_reg     <= sub_cnt_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      pix_valid_reg   <= pix_valid_next;
      frame_start_reg <= vs_le;
      locked_reg      <= (state_next == ST_LOCKED);
      err_line_reg    <= err_line_c;
      err_frame_reg   <= err_frame_c;
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign pix_valid   = pix_valid_reg;
  assign frame_start = frame_start_reg;
  assign locked      = locked_reg;
  assign err_line    = err_line_reg;
  assign err_frame   = err_frame_reg;

`ifdef VGA_DEC_STATS_EN
  logic [15:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (!reset)
      err_count_reg <= '0;
    else if ((err_line_reg || err_frame_reg) && (err_count_reg != 16'hFFFF))
      err_count_reg <= err_count_reg + 16'd1;
  end

  assign err_count = err_count_reg;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 20x10 raster (12x6 active).
module tb_vga_sync_decoder;

  localparam int HT  = 20;
  localparam int VT  = 10;
  localparam int CPP = 2;
`ifdef VGA_DEC_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, hs, vs, video;
  logic [9:0]  x, y;
  logic        pix_valid, frame_start, locked, err_line, err_frame;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .CLKS_PER_PIX(CPP), .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk(clk), .reset(reset), .hs(hs), .vs(vs), .video(video),
    .x(x), .y(y), .pix_valid(pix_valid), .frame_start(frame_start),
    .locked(locked), .err_line(err_line), .err_frame(err_frame),
    .err_count(err_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int pv_cnt = 0, pv_x11 = 0, pv_oob = 0, pv_y0 = 0;
  int fs_q[$], lock_q[$], unlock_q[$], el_q[$], ef_q[$], vs_drv_q[$];
  int hs_drv_last = 0;
  int b_fs, b_lk, b_ul, b_el, b_ef, b_pv, b_x11, b_oob, b_y0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -100000;
  endfunction

  // Output monitor: samples 2 time units after each rising edge.
  logic locked_prev = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (pix_valid) begin
        pv_cnt++;
        if (x == 10'd11) pv_x11++;
        if (x > 10'd11 || y > 10'd5) pv_oob++;
        if (x == 10'd0 && y == 10'd0) pv_y0++;
      end
      if (frame_start) fs_q.push_back(cyc);
      if (locked && !locked_prev) lock_q.push_back(cyc);
      if (!locked && locked_prev) unlock_q.push_back(cyc);
      if (err_line) el_q.push_back(cyc);
      if (err_frame) ef_q.push_back(cyc);
      locked_prev = locked;
    end
  end

  task automatic snap();
    b_fs = fs_q.size(); b_lk = lock_q.size(); b_ul = unlock_q.size();
    b_el = el_q.size(); b_ef = ef_q.size();
    b_pv = pv_cnt; b_x11 = pv_x11; b_oob = pv_oob; b_y0 = pv_y0;
  endtask

  task automatic drive(input logic h_i, input logic v_i, input logic d_i);
    @(posedge clk);
    #5;
    if (hs && !h_i) hs_drv_last = cyc;
    if (vs && !v_i) vs_drv_q.push_back(cyc);
    hs = h_i;
    vs = v_i;
    video = d_i;
  endtask

  // One frame of the reduced raster; hs active at h=14..15, vs active for two
  // lines from v=7 (from the hs edge of line 7 when coin is set).
  task automatic run_frame(input int lines, input int short_v, input bit coin, input int max_pix);
    int  hlen;
    int  p;
    bit  hs_a, vs_a, vid_a;
    p = 0;
    for (int v = 0; v < lines; v++) begin
      hlen = (v == short_v) ? HT - 1 : HT;
      for (int h = 0; h < hlen; h++) begin
        if (max_pix >= 0 && p >= max_pix) return;
        hs_a  = (h >= 14 && h < 16);
        vs_a  = coin ? ((v == 7 && h >= 14) || v == 8 || (v == 9 && h < 14))
                     : (v == 7 || v == 8);
        vid_a = (h < 12 && v < 6);
        repeat (CPP) drive(!hs_a, !vs_a, vid_a);
        p++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; hs = 1'b1; vs = 1'b1; video = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #3;
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_pulses", int'({pix_valid, frame_start, err_line, err_frame}), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_err_count", int'(err_count), 0);
      #2;
      hs = ~hs; vs = ~vs; video = ~video;
    end
    @(posedge clk);
    #5;
    hs = 1'b1; vs = 1'b1; video = 1'b0; reset = 1'b1;

    // Three clean frames
    snap();
    run_frame(VT, -1, 1'b0, -1);
    check("clean_fs_latency", qat(fs_q, 0) - qat(vs_drv_q, 0), 2);
    b_pv = pv_cnt; b_x11 = pv_x11; b_oob = pv_oob; b_y0 = pv_y0;
    run_frame(VT, -1, 1'b0, -1);
    run_frame(VT, -1, 1'b0, -1);
    check("clean_frame_starts", fs_q.size() - b_fs, 3);
    check("clean_lock_at_vs2", qat(lock_q, b_lk), qat(fs_q, b_fs + 1));
    check("clean_pix_count", pv_cnt - b_pv, 144);
    check("clean_x_last_count", pv_x11 - b_x11, 12);
    check("clean_out_of_range", pv_oob - b_oob, 0);
    check("clean_origin_count", pv_y0 - b_y0, 2);
    check("clean_err_line", el_q.size() - b_el, 0);
    check("clean_err_frame", ef_q.size() - b_ef, 0);
    check("clean_locked", int'(locked), 1);

    // One 19-pixel line in a locked stream
    snap();
    run_frame(VT, 3, 1'b0, -1);
    check("short_locked_after_f1", int'(locked), 0);
    run_frame(VT, -1, 1'b0, -1);
    check("short_err_line", el_q.size() - b_el, 1);
    check("short_unlock_delay", qat(unlock_q, b_ul) - qat(el_q, b_el), 1);
    check("short_err_frame", ef_q.size() - b_ef, 0);
    check("short_relock_vs2", qat(lock_q, b_lk), qat(fs_q, b_fs + 1));
    check("short_locked", int'(locked), 1);
    check("short_err_count", int'(err_count), STATS);

    // A frame one line short
    snap();
    run_frame(VT - 1, -1, 1'b0, -1);
    run_frame(VT, -1, 1'b0, -1);
    run_frame(VT, -1, 1'b0, -1);
    check("short_frame_acq_locked", int'(locked), 0);
    run_frame(VT, -1, 1'b0, -1);
    check("frame_err_count", ef_q.size() - b_ef, 1);
    check("frame_err_at_vs", qat(ef_q, b_ef), qat(fs_q, b_fs + 1));
    check("frame_err_line", el_q.size() - b_el, 0);
    check("frame_relock", qat(lock_q, b_lk), qat(fs_q, b_fs + 3));
    check("frame_locked", int'(locked), 1);
    check("frame_err_count_stat", int'(err_count), 2 * STATS);

    // hs idle long enough to saturate the line counter
    snap();
    repeat (5000) drive(1'b1, 1'b1, 1'b0);
    check("idle_err_line", el_q.size() - b_el, 1);
    check("idle_sat_time", qat(el_q, b_el) - hs_drv_last, 4096);
    check("idle_err_frame", ef_q.size() - b_ef, 0);
    check("idle_locked", int'(locked), 0);
    check("idle_err_count", int'(err_count), 3 * STATS);

    // Coincident hs/vs leading edges
    snap();
    run_frame(VT, -1, 1'b1, -1);
    run_frame(VT, -1, 1'b1, -1);
    run_frame(VT, -1, 1'b1, -1);
    check("coin_err_frame", ef_q.size() - b_ef, 0);
    check("coin_err_line", el_q.size() - b_el, 0);
    check("coin_locked", int'(locked), 1);

    // Reset in the middle of active line 2
    run_frame(VT, -1, 1'b1, 2 * HT + 6);
    @(posedge clk);
    #3;
    check("mid_pre_x", int'(x), 5);
    check("mid_pre_y", int'(y), 2);
    check("mid_pre_locked", int'(locked), 1);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #3;
    check("mid_rst_x", int'(x), 0);
    check("mid_rst_y", int'(y), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_err_count", int'(err_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receiving end of the 640x480 VGA timing interface. Consumes hs/vs/video as produced by the timing generator and rebuilds pixel/line coordinates from them.
- Measures line and frame lengths against nominal timing and reports lock and timing errors.
- Sits beside the timing generator and draw logic as an on-chip timing monitor. Also feeds coordinates to downstream capture/overlay logic that sees only sync signals.

Parameters:
- H_TOTAL, 800: pixels per line, including blanking.
- V_TOTAL, 525: lines per frame.
- CLKS_PER_PIX, 2: clk cycles per pixel (50 MHz clk, 25 MHz pixel rate).
- HS_POL, 0: active level of hs (0 = active-low).
- VS_POL, 0: active level of vs (0 = active-low).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- hs  in  1  horizontal sync from the timing generator.
- vs  in  1  vertical sync from the timing generator.
- video  in  1  active-video flag from the timing generator.
- x  out  10  pixel column within the active line.
- y  out  10  active line index within the frame.
- pix_valid  out  1  one-clk strobe on the first clk of each active pixel.
- frame_start  out  1  one-clk pulse on each vs leading edge.
- locked  out  1  high while the timing is verified.
- err_line  out  1  one-clk pulse on a bad line length.
- err_frame  out  1  one-clk pulse on a bad frame length.
- err_count  out  16  saturating error counter (see Optional Feature).

Behaviour:
- Reset: clk is the single clock; reset is synchronous and active-low. While reset=0 at a clk edge, all outputs and all state go to 0 and the FSM goes to SEARCH.
- Input stage: hs, vs and video are each registered once. The leading edge of a sync is the transition into its active level (per HS_POL / VS_POL). Every output is 2 clks behind the input that caused it: 1 register stage plus 1 output register.
- Line measurement: clk_cnt (12 bit, saturates at 4095) clears on each hs leading edge. At every hs leading edge after the first one since reset/SEARCH, compare the count against H_TOTAL*CLKS_PER_PIX. If it differs, pulse err_line. If clk_cnt saturates, pulse err_line once and hold it saturated until the next hs edge.
- Frame measurement: line_cnt (10 bit, saturates at 1023) increments on each hs leading edge. At each vs leading edge:
  - Compare line_cnt against V_TOTAL, but only in ACQUIRE or LOCKED.
  - If it differs, pulse err_frame.
  - Then clear line_cnt.
  - If hs and vs leading edges fall in the same clk, the hs edge counts toward the frame that is closing.
- Coordinates:
  - On a vs leading edge, set first_line.
  - On a video rising edge: if first_line, y=0 and first_line clears; otherwise y=y+1, saturating at 1023.
  - On a video rising edge, x=0, pix_valid=1, and the sub-pixel counter clears.
  - While video=1, x increments and pix_valid pulses every CLKS_PER_PIX clks. x saturates at 1023.
  - x and y hold their values during blanking.
- FSM with states SEARCH, ACQUIRE, LOCKED:
  - SEARCH: on a vs leading edge, go to ACQUIRE.
  - ACQUIRE: on the next vs leading edge, go to LOCKED if no err_line/err_frame occurred during the frame. Otherwise stay in ACQUIRE and restart the check.
  - LOCKED: any err_line or err_frame goes to SEARCH in the next clk.
  - locked = (state == LOCKED), registered.
- frame_start pulses on every vs leading edge, in every state.
- Reset mid-frame: all state is discarded. The first partial line/frame after reset is never flagged.

Optional Feature:
- Macro: VGA_DEC_STATS_EN.
- Defined: err_count increments on each clk where err_line or err_frame is 1 (+1 even if both fire), saturates at 65535, and clears only on reset.
- Undefined: the counter logic is not built and err_count is driven constant 0. The port list does not change.

Decomposition:
- Package vga_dec_pkg holds:
  - The FSM state enum (SEARCH/ACQUIRE/LOCKED).
  - Count-width constants CLK_CNT_W=12, LINE_CNT_W=10, COORD_W=10.
  - Nominal 640x480 timing constants.
- Sub-module vga_edge_det (one input register plus polarity-aware leading/rising edge pulse), instantiated for hs, vs and video.

Test Plan:
- Hold reset=0 for 3 clks with toggling inputs -> all outputs 0, locked=0.
- Drive 3 clean frames from the timing generator -> frame_start on each vs edge; locked=1 from the 2nd vs edge + 2 clks. Each frame gives 307200 pix_valid strobes, x range 0..639, y range 0..479, no error pulses.
- In a locked stream, shorten one line to 799 pixels (1598 clks) -> one err_line; locked=0 the next clk. Relock at the 2nd following vs edge. err_count=1 with VGA_DEC_STATS_EN defined, 0 without.
- Send a frame of 524 lines -> err_frame at that vs edge; the next frame stays in ACQUIRE; LOCKED after one more clean frame.
- Hold hs inactive for 5000 clks -> a single err_line at saturation (clk_cnt=4095) and no further pulses until an hs edge arrives.
- Make the hs and vs leading edges coincide, with the frame otherwise 525 lines -> no err_frame. Then assert reset=0 mid-line -> x=y=0 and locked=0 at the next clk.
